// File: rtl/alu_pkg.sv
// ============================================================================
// Package  : alu_pkg
// Purpose  : ALU opcode encoding and dispatch FSM state encoding.
// Revision : 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NOR  = 3'd3,
    OP_LESS = 3'd4,
    OP_ADD  = 3'd5,
    OP_SUB  = 3'd6,
    OP_MOD  = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/alu_dispatch_fifo.sv
// ============================================================================
// Module   : alu_dispatch_fifo
// Purpose  : Request queue for alu_dispatch; registered occupancy count.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_dispatch_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 72
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic [DATA_W-1:0]       push_data,
  input  logic                    pop,
  output logic [DATA_W-1:0]       pop_data,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign do_push  = push && (count != FULL_CNT);
  assign do_pop   = pop && (count != '0);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_dispatch.sv
// ============================================================================
// Module   : alu_dispatch
// Purpose  : In-order request queue feeding a single-issue ALU, one op in flight.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_dispatch #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             in_a,
  input  logic [31:0]             in_b,
  input  logic [2:0]              in_op,
  input  logic [TAG_W-1:0]        in_tag,
  output logic [31:0]             alu_a,
  output logic [31:0]             alu_b,
  output logic [2:0]              alu_op,
  input  logic [31:0]             alu_result,
  input  logic                    alu_c,
  input  logic                    alu_we,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             out_result,
  output logic                    out_c,
  output logic [TAG_W-1:0]        out_tag,
  output logic [$clog2(DEPTH):0]  count
);

  import alu_pkg::*;

  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int DATA_W = 32 + 32 + 3 + TAG_W;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  state_t            state;
  state_t            state_nx;
  logic              ready_en;
  logic              push;
  logic              pop;
  logic              capture;
  logic [DATA_W-1:0] head;
  logic [TAG_W-1:0]  cur_tag;

  // ready_en keeps in_ready low during reset and lifts it on the first edge after.
  assign in_ready  = ready_en && (count < FULL_CNT);
  assign push      = in_valid && in_ready;
  assign out_valid = (state == ST_HOLD);

  alu_dispatch_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({in_a, in_b, in_op, in_tag}),
    .pop       (pop),
    .pop_data  (head),
    .count     (count)
  );

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    capture  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (count != '0) begin
          pop      = 1'b1;
          state_nx = ST_ISSUE;
        end
      end
      // The strobe is ignored here: it may still belong to the previous op.
      ST_ISSUE: begin
        state_nx = ST_WAIT;
      end
      ST_WAIT: begin
        if (alu_we) begin
          capture  = 1'b1;
          state_nx = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          if (count != '0) begin
            pop      = 1'b1;
            state_nx = ST_ISSUE;
          end else begin
            state_nx = ST_IDLE;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      ready_en   <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      cur_tag    <= '0;
      out_result <= '0;
      out_c      <= 1'b0;
      out_tag    <= '0;
    end else begin
      state    <= state_nx;
      ready_en <= 1'b1;
      if (pop) begin
        alu_a   <= head[DATA_W-1 -: 32];
        alu_b   <= head[DATA_W-33 -: 32];
        alu_op  <= head[TAG_W+2 -: 3];
        cur_tag <= head[TAG_W-1:0];
      end
      if (capture) begin
        out_result <= alu_result;
        out_c      <= alu_c;
        out_tag    <= cur_tag;
      end
    end
  end

endmodule

`default_nettype wire
